ps2_key_decoder: RTL



---
 rtl/ps2_pkg.sv | 34 +++
 rtl/ps2_ascii_lut.sv | 50 +++++
 rtl/ps2_key_decoder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 set-2 key decoder.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GOT_E0,
      ST_GOT_F0,
      ST_GOT_E0F0
   } ps2_state_e;

   localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
   localparam logic [7:0] PS2_LSHIFT     = 8'h12;
   localparam logic [7:0] PS2_RSHIFT     = 8'h59;
   localparam logic [7:0] PS2_CAPS       = 8'h58;
   localparam logic [7:0] PS2_RESP_BAT   = 8'hAA;
   localparam logic [7:0] PS2_RESP_ACK   = 8'hFA;
   localparam logic [7:0] PS2_RESP_ECHO  = 8'hEE;
   localparam logic [7:0] PS2_RESP_RSND  = 8'hFE;

   // 'release' is a reserved word, hence the short field names.
   typedef struct packed {
      logic       rel;
      logic       ext;
      logic [7:0] scan;
      logic [7:0] ascii;
   } ps2_event_t;

   function automatic logic is_dev_resp(input logic [7:0] b);
      return (b == PS2_RESP_BAT) || (b == PS2_RESP_ACK) ||
             (b == PS2_RESP_ECHO) || (b == PS2_RESP_RSND);
   endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// Combinational set-2 make code to ASCII translation with Shift/Caps handling.
module ps2_ascii_lut
   import ps2_pkg::*;
(
   input  logic [7:0] i_scan,
   input  logic       i_shift,
   input  logic       i_caps,
   output logic [7:0] o_ascii
);

   logic [7:0] lc;   // lowercase letter, 0 if not a letter
   logic [7:0] dg;   // unshifted digit-row char
   logic [7:0] ds;   // shifted digit-row char

   always_comb begin
      o_ascii = 8'h00;
      lc      = 8'h00;
      dg      = 8'h00;
      ds      = 8'h00;
      case (i_scan)
         8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
         8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
         8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
         8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
         8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
         8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
         8'h35: lc = "y";  8'h1A: lc = "z";
         8'h16: begin dg = "1"; ds = "!"; end
         8'h1E: begin dg = "2"; ds = "@"; end
         8'h26: begin dg = "3"; ds = "#"; end
         8'h25: begin dg = "4"; ds = "$"; end
         8'h2E: begin dg = "5"; ds = "%"; end
         8'h36: begin dg = "6"; ds = "^"; end
         8'h3D: begin dg = "7"; ds = "&"; end
         8'h3E: begin dg = "8"; ds = "*"; end
         8'h46: begin dg = "9"; ds = "("; end
         8'h45: begin dg = "0"; ds = ")"; end
         8'h29: o_ascii = 8'h20;
         8'h5A: o_ascii = 8'h0D;
         8'h66: o_ascii = 8'h08;
         8'h0D: o_ascii = 8'h09;
         default: o_ascii = 8'h00;
      endcase
      if (lc != 8'h00)
         o_ascii = (i_shift ^ i_caps) ? (lc - 8'h20) : lc;
      else if (dg != 8'h00)
         o_ascii = i_shift ? ds : dg;
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// Folds E0/F0 prefixes into key events, tracks Shift/Caps, queues events in a FWFT FIFO.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [7:0]        i_byte,
   input  logic              i_byte_valid,
   input  logic              i_rd_en,
   output logic              o_valid,
   output logic [7:0]        o_scan,
   output logic              o_release,
   output logic              o_extended,
   output logic [7:0]        o_ascii,
   output logic [ADDR_W:0]   o_count,
   output logic              o_overflow,
   output logic              o_shift,
   output logic              o_caps
);

   ps2_state_e state_q, state_d;
   logic       lshift_q, lshift_d, rshift_q, rshift_d;
   logic       caps_q, caps_d, held_q, held_d;
   logic       emit, ev_rel, ev_ext;
   logic [7:0] lut_ascii;
   ps2_event_t ev;

   ps2_event_t        mem [FIFO_DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [ADDR_W:0]   count_q;
   logic              ovf_q;
   logic              full, pop, do_wr;

   ps2_ascii_lut u_lut (
      .i_scan  (i_byte),
      .i_shift (lshift_q | rshift_q),
      .i_caps  (caps_q),
      .o_ascii (lut_ascii)
   );

   always_comb begin
      state_d = state_q;
      emit    = 1'b0;
      ev_rel  = 1'b0;
      ev_ext  = 1'b0;
      if (i_byte_valid) begin
         case (state_q)
            ST_GOT_E0: begin
               if (i_byte == PS2_PREFIX_BRK)      state_d = ST_GOT_E0F0;
               else if (i_byte != PS2_PREFIX_EXT) begin
                  emit = 1'b1; ev_ext = 1'b1; state_d = ST_IDLE;
               end
            end
            ST_GOT_F0: begin
               if (i_byte == PS2_PREFIX_EXT)      state_d = ST_GOT_E0;
               else if (i_byte != PS2_PREFIX_BRK) begin
                  emit = 1'b1; ev_rel = 1'b1; state_d = ST_IDLE;
               end
            end
            ST_GOT_E0F0: begin
               // A stray prefix here restarts the sequence rather than emitting.
               if (i_byte == PS2_PREFIX_EXT)      state_d = ST_GOT_E0;
               else if (i_byte == PS2_PREFIX_BRK) state_d = ST_GOT_F0;
               else begin
                  emit = 1'b1; ev_ext = 1'b1; ev_rel = 1'b1; state_d = ST_IDLE;
               end
            end
            default: begin
               if (i_byte == PS2_PREFIX_EXT)      state_d = ST_GOT_E0;
               else if (i_byte == PS2_PREFIX_BRK) state_d = ST_GOT_F0;
               else if (!is_dev_resp(i_byte))     emit = 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      lshift_d = lshift_q;
      rshift_d = rshift_q;
      caps_d   = caps_q;
      held_d   = held_q;
      if (emit && !ev_ext) begin
         if (i_byte == PS2_LSHIFT) lshift_d = !ev_rel;
         if (i_byte == PS2_RSHIFT) rshift_d = !ev_rel;
         if (i_byte == PS2_CAPS) begin
            // Auto-repeat of a held Caps Lock must not toggle again.
            if (!ev_rel && !held_q) caps_d = !caps_q;
            held_d = !ev_rel;
         end
      end
   end

   always_comb begin
      ev.rel   = ev_rel;
      ev.ext   = ev_ext;
      ev.scan  = i_byte;
      ev.ascii = (ev_rel || ev_ext) ? 8'h00 : lut_ascii;
   end

   assign full  = (count_q == (ADDR_W+1)'(FIFO_DEPTH));
   assign pop   = i_rd_en && (count_q != '0);
   assign do_wr = emit && (!full || pop);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         lshift_q <= 1'b0;
         rshift_q <= 1'b0;
         caps_q   <= 1'b0;
         held_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         lshift_q <= lshift_d;
         rshift_q <= rshift_d;
         caps_q   <= caps_d;
         held_q   <= held_d;
         if (do_wr) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
         if (do_wr && !pop)      count_q <= count_q + (ADDR_W+1)'(1);
         else if (!do_wr && pop) count_q <= count_q - (ADDR_W+1)'(1);
         if (emit && full && !pop) ovf_q <= 1'b1;
      end
   end

   // When full with a simultaneous pop, the write slot is the head being popped.
   always_ff @(posedge i_clk) begin
      if (!i_rst && do_wr) mem[wr_ptr_q] <= ev;
   end

   assign o_valid    = (count_q != '0);
   assign o_scan     = o_valid ? mem[rd_ptr_q].scan  : 8'h00;
   assign o_release  = o_valid ? mem[rd_ptr_q].rel   : 1'b0;
   assign o_extended = o_valid ? mem[rd_ptr_q].ext   : 1'b0;
   assign o_ascii    = o_valid ? mem[rd_ptr_q].ascii : 8'h00;
   assign o_count    = count_q;
   assign o_overflow = ovf_q;
   assign o_shift    = lshift_q | rshift_q;
   assign o_caps     = caps_q;

endmodule
